// File: rtl/ram_mfc_ctrl.sv
// Byte-addressable RAM with a MOV/MOC handshake, programmable wait states and
// big-endian byte, halfword and word accesses with alignment and range checking.
module ram_mfc_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CHECK_ALIGN = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [1:0]        TYPE,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC,
  output logic              ERR,
  output logic              BUSY
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        type_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic              latch_en;

  logic [7:0] mem [DEPTH];

  logic              in_idle;
  logic              acc_rw;
  logic [ADDR_W-1:0] acc_addr;
  logic [1:0]        acc_type;
  logic [31:0]       acc_din;
  logic [1:0]        acc_off;
  logic              size_err, align_err, range_err, acc_err;
  logic [ADDR_W:0]   acc_last;
  logic [ADDR_W-1:0] byte_addr [4];
  logic [31:0]       rd_word, rd_data, wdata_al;
  logic              do_access;

  // With zero wait states the access happens on the sampling edge, so it
  // must use the live inputs; otherwise the latched copies are used.
  always_comb begin
    in_idle  = (state_q == StIdle);
    acc_rw   = in_idle ? RW      : rw_q;
    acc_addr = in_idle ? ADDR    : addr_q;
    acc_type = in_idle ? TYPE    : type_q;
    acc_din  = in_idle ? DATA_IN : din_q;
  end

  always_comb begin
    acc_off  = 2'd0;
    size_err = 1'b0;
    wdata_al = acc_din;
    case (acc_type)
      2'b00: begin
        acc_off  = 2'd0;
        wdata_al = {acc_din[7:0], 24'b0};
      end
      2'b01: begin
        acc_off  = 2'd1;
        wdata_al = {acc_din[15:0], 16'b0};
      end
      2'b10: acc_off = 2'd3;
      default: size_err = 1'b1;
    endcase
    align_err = (CHECK_ALIGN != 0) &&
                ((acc_type == 2'b01 && acc_addr[0]) ||
                 (acc_type == 2'b10 && acc_addr[1:0] != 2'b00));
    // DEPTH is 2**ADDR_W, so a carry into the top bit means past the end.
    acc_last  = {1'b0, acc_addr} + {{(ADDR_W-1){1'b0}}, acc_off};
    range_err = acc_last[ADDR_W];
    acc_err   = size_err | align_err | range_err;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = acc_addr + ADDR_W'(i);
    end
    rd_word = {mem[byte_addr[0]], mem[byte_addr[1]], mem[byte_addr[2]], mem[byte_addr[3]]};
    case (acc_type)
      2'b00:   rd_data = {24'b0, rd_word[31:24]};
      2'b01:   rd_data = {16'b0, rd_word[31:16]};
      default: rd_data = rd_word;
    endcase
  end

  assign do_access = MOV && ((in_idle && WAIT_CYCLES == 0) ||
                             (state_q == StWait && cnt_q <= 4'd1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    dout_d   = dout_q;
    latch_en = 1'b0;
    case (state_q)
      StIdle: begin
        if (MOV) begin
          latch_en = 1'b1;
          cnt_d    = 4'(WAIT_CYCLES);
          state_d  = (WAIT_CYCLES == 0) ? StDone : StWait;
        end
      end
      StWait: begin
        if (!MOV) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StDone;
          cnt_d   = 4'd0;
        end
      end
      StDone: begin
        if (!MOV) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (do_access) begin
      err_d = acc_err;
      if (acc_rw && !acc_err) dout_d = rd_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      type_q  <= 2'b00;
      din_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      if (latch_en) begin
        rw_q   <= RW;
        addr_q <= ADDR;
        type_q <= TYPE;
        din_q  <= DATA_IN;
      end
    end
  end

  // Memory is never reset; CLR only suppresses a write on the same edge.
  always_ff @(posedge CLK) begin
    if (!CLR && do_access && !acc_rw && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (i <= int'(acc_off)) mem[byte_addr[i]] <= wdata_al[8*(3-i) +: 8];
      end
    end
  end

  assign DATA_OUT = dout_q;
  assign MOC      = (state_q == StDone);
  assign ERR      = err_q;
  assign BUSY     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_mfc_ctrl.sv
// Bench for ram_mfc_ctrl: instance A (2 wait states, alignment checked) and
// instance B (zero wait states, unaligned allowed) against a byte-array model.
module tb_ram_mfc_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mov_a = 1'b0, mov_b = 1'b0;
  logic        rw = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [1:0]  typ = 2'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout_a, dout_b;
  logic        moc_a, moc_b, err_a, err_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [2][DEPTH];
  logic [31:0] ref_dout [2];

  ram_mfc_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2), .CHECK_ALIGN(1)) u_a (
    .CLK(clk), .CLR(clr), .MOV(mov_a), .RW(rw), .ADDR(addr), .TYPE(typ), .DATA_IN(din),
    .DATA_OUT(dout_a), .MOC(moc_a), .ERR(err_a), .BUSY(busy_a)
  );

  ram_mfc_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0), .CHECK_ALIGN(0)) u_b (
    .CLK(clk), .CLR(clr), .MOV(mov_b), .RW(rw), .ADDR(addr), .TYPE(typ), .DATA_IN(din),
    .DATA_OUT(dout_b), .MOC(moc_b), .ERR(err_b), .BUSY(busy_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic cur_moc(input int s);
    return (s != 0) ? moc_b : moc_a;
  endfunction
  function automatic logic cur_err(input int s);
    return (s != 0) ? err_b : err_a;
  endfunction
  function automatic logic cur_busy(input int s);
    return (s != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic [31:0] cur_dout(input int s);
    return (s != 0) ? dout_b : dout_a;
  endfunction

  task automatic set_mov(input int s, input logic v);
    if (s != 0) mov_b = v;
    else        mov_a = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Applies the access rules to the byte-array model; returns the error flag.
  function automatic logic model(input int s, input bit r, input logic [7:0] a,
                                 input logic [1:0] t, input logic [31:0] d);
    int n;
    logic [31:0] v;
    if (t == 2'b11) return 1'b1;
    n = 1 << t;
    if (int'(a) + n > DEPTH) return 1'b1;
    if (s == 0 && (int'(a) % n) != 0) return 1'b1;
    if (r) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[s][int'(a) + i]);
      ref_dout[s] = v;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[s][int'(a) + i] = 8'(d >> (8 * (n - 1 - i)));
    end
    return 1'b0;
  endfunction

  task automatic op(input int s, input bit r, input logic [7:0] a, input logic [1:0] t,
                    input logic [31:0] d, input int hold,
                    output logic [31:0] got_dout, output logic got_err);
    int lat;
    logic exp_err;
    exp_err = model(s, r, a, t, d);
    @(negedge clk);
    rw = r; addr = a; typ = t; din = d;
    set_mov(s, 1'b1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (cur_moc(s)) break;
      // Past the sampling edge the inputs must be ignored.
      rw = 1'($urandom); addr = 8'($urandom); typ = 2'($urandom); din = $urandom;
    end
    chk("moc_latency", 32'(lat), (s != 0) ? 32'd1 : 32'd3);
    got_err  = cur_err(s);
    got_dout = cur_dout(s);
    chk("err_model", 32'(got_err), 32'(exp_err));
    chk("dout_model", got_dout, ref_dout[s]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("moc_hold", 32'(cur_moc(s)), 32'd1);
    end
    @(negedge clk);
    set_mov(s, 1'b0);
    @(posedge clk); #1;
    chk("moc_release", 32'(cur_moc(s)), 32'd0);
    chk("err_release", 32'(cur_err(s)), 32'd0);
    chk("busy_release", 32'(cur_busy(s)), 32'd0);
  endtask

  typedef struct {
    int          s;
    bit          rw;
    logic [7:0]  a;
    logic [1:0]  t;
    logic [31:0] d;
    logic [31:0] x_dout;
    logic        x_err;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [31:0] gd;
    logic        ge;
    int          s;
    logic [7:0]  a;

    tbl[0]  = '{0, 1'b0, 8'h10, 2'b10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{0, 1'b1, 8'h10, 2'b10, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{0, 1'b1, 8'h13, 2'b00, 32'h0,        32'h000000EF, 1'b0};
    tbl[3]  = '{0, 1'b1, 8'h12, 2'b01, 32'h0,        32'h0000BEEF, 1'b0};
    tbl[4]  = '{0, 1'b0, 8'h11, 2'b00, 32'h00000055, 32'h0000BEEF, 1'b0};
    tbl[5]  = '{0, 1'b1, 8'h10, 2'b10, 32'h0,        32'hDE55BEEF, 1'b0};
    tbl[6]  = '{0, 1'b1, 8'h11, 2'b10, 32'h0,        32'hDE55BEEF, 1'b1};
    tbl[7]  = '{0, 1'b1, 8'h13, 2'b01, 32'h0,        32'hDE55BEEF, 1'b1};
    tbl[8]  = '{0, 1'b1, 8'h10, 2'b11, 32'h0,        32'hDE55BEEF, 1'b1};
    tbl[9]  = '{0, 1'b0, 8'h12, 2'b10, 32'hCAFEF00D, 32'hDE55BEEF, 1'b1};
    tbl[10] = '{0, 1'b1, 8'h10, 2'b10, 32'h0,        32'hDE55BEEF, 1'b0};
    tbl[11] = '{1, 1'b0, 8'hFC, 2'b10, 32'h11223344, 32'h00000000, 1'b0};
    tbl[12] = '{1, 1'b1, 8'hFC, 2'b10, 32'h0,        32'h11223344, 1'b0};
    tbl[13] = '{1, 1'b0, 8'h00, 2'b10, 32'hA5A5A5A5, 32'h11223344, 1'b0};
    tbl[14] = '{1, 1'b0, 8'hFE, 2'b10, 32'h99887766, 32'h11223344, 1'b1};
    tbl[15] = '{1, 1'b1, 8'h00, 2'b01, 32'h0,        32'h0000A5A5, 1'b0};
    tbl[16] = '{1, 1'b1, 8'hFE, 2'b10, 32'h0,        32'h0000A5A5, 1'b1};
    tbl[17] = '{1, 1'b1, 8'hFF, 2'b01, 32'h0,        32'h0000A5A5, 1'b1};
    tbl[18] = '{1, 1'b1, 8'h01, 2'b01, 32'h0,        32'h0000A5A5, 1'b0};

    ref_dout[0] = 32'd0;
    ref_dout[1] = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_moc", 32'(cur_moc(i)), 32'd0);
      chk("reset_err", 32'(cur_err(i)), 32'd0);
      chk("reset_busy", 32'(cur_busy(i)), 32'd0);
      chk("reset_dout", cur_dout(i), 32'd0);
    end
    @(negedge clk);
    clr = 1'b0;

    // Give both memories known contents.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < DEPTH; w += 4) begin
        op(i, 1'b0, 8'(w), 2'b10, $urandom, 0, gd, ge);
      end
    end

    for (int i = 0; i < 19; i++) begin
      op(tbl[i].s, tbl[i].rw, tbl[i].a, tbl[i].t, tbl[i].d, 0, gd, ge);
      chk($sformatf("tbl%0d_dout", i), gd, tbl[i].x_dout);
      chk($sformatf("tbl%0d_err", i), 32'(ge), 32'(tbl[i].x_err));
    end

    // Abort: MOV dropped after one wait edge.
    @(negedge clk);
    rw = 1'b0; addr = 8'h20; typ = 2'b10; din = 32'h12345678; mov_a = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy_a), 32'd1);
    chk("abort_moc0", 32'(moc_a), 32'd0);
    @(posedge clk); #1;
    chk("abort_moc1", 32'(moc_a), 32'd0);
    @(negedge clk);
    mov_a = 1'b0;
    @(posedge clk); #1;
    chk("abort_moc2", 32'(moc_a), 32'd0);
    chk("abort_idle", 32'(busy_a), 32'd0);
    chk("abort_dout", dout_a, ref_dout[0]);
    op(0, 1'b1, 8'h20, 2'b10, 32'h0, 0, gd, ge);

    // Reset while waiting drops the pending write and clears DATA_OUT.
    @(negedge clk);
    rw = 1'b0; addr = 8'h20; typ = 2'b10; din = 32'h0BADF00D; mov_a = 1'b1;
    @(posedge clk); #1;
    chk("clr_busy_before", 32'(busy_a), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_moc", 32'(moc_a), 32'd0);
    chk("clr_busy", 32'(busy_a), 32'd0);
    chk("clr_dout_a", dout_a, 32'd0);
    chk("clr_dout_b", dout_b, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    mov_a = 1'b0;
    ref_dout[0] = 32'd0;
    ref_dout[1] = 32'd0;
    op(0, 1'b1, 8'h20, 2'b10, 32'h0, 0, gd, ge);

    // Zero-wait instance: MOV held for several cycles, single write.
    op(1, 1'b0, 8'h40, 2'b00, 32'h0000007E, 5, gd, ge);
    op(1, 1'b1, 8'h40, 2'b00, 32'h0, 5, gd, ge);
    chk("hold_read", gd, 32'h0000007E);

    for (int i = 0; i < 80; i++) begin
      s = int'($urandom_range(1, 0));
      a = ($urandom_range(3, 0) == 0) ? 8'(252 + $urandom_range(3, 0)) : 8'($urandom);
      op(s, 1'($urandom), a, 2'($urandom), $urandom, int'($urandom_range(2, 0)), gd, ge);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
